// File: rtl/writeback_queue_if.sv
// -----------------------------------------------------------------------------
// writeback_queue_if
//   Bundles the three execute-unit result buses (X, Y, M) and the
//   register-file write port of the writeback queue.
//
//   master modport : the environment side. Drives the unit results and
//                    observes the register-file write port, stall and status.
//   slave modport  : the queue side. Samples the unit results and drives the
//                    write port, stall, sticky overflow and occupancy.
//
//   DEPTH must match the DEPTH of the writeback_queue it is connected to,
//   because it sets the width of wb_count.
// -----------------------------------------------------------------------------
interface writeback_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Execute-unit results
  logic [4:0]    x_wb_regdest;
  logic          x_wb_writereg;
  logic [31:0]   x_wb_wbvalue;
  logic [4:0]    y_wb_regdest;
  logic          y_wb_writereg;
  logic [31:0]   y_wb_wbvalue;
  logic [4:0]    m_wb_regdest;
  logic          m_wb_writereg;
  logic [31:0]   m_wb_wbvalue;

  // Register-file write port and status
  logic          wb_reg_en;
  logic [4:0]    wb_reg_addr;
  logic [31:0]   wb_reg_data;
  logic          wb_is_stall;
  logic          wb_overflow;
  logic [CW-1:0] wb_count;

  modport master (
    output x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    output y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    output m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
    input  wb_reg_en, wb_reg_addr, wb_reg_data,
    input  wb_is_stall, wb_overflow, wb_count
  );

  modport slave (
    input  x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    input  y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    input  m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
    output wb_reg_en, wb_reg_addr, wb_reg_data,
    output wb_is_stall, wb_overflow, wb_count
  );
endinterface

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//   Order-preserving writeback queue between the X, Y and M execute units and
//   the single register-file write port. Every qualified result (writereg=1,
//   regdest!=0) completing in a cycle is enqueued into one shared circular
//   FIFO in M, X, Y order; one entry per cycle is drained onto wb_reg_*.
//   A stall is raised toward Issue when free space falls to STALL_MARGIN.
//
//   Ports:
//     clock : single clock, rising edge
//     reset : synchronous, active-low
//     wbq   : writeback_queue_if.slave
//             in  {x,y,m}_wb_regdest[4:0], _writereg, _wbvalue[31:0]
//             out wb_reg_en, wb_reg_addr[4:0], wb_reg_data[31:0] (registered)
//             out wb_is_stall (registered), wb_overflow (sticky)
//             out wb_count[log2(DEPTH):0] (registered occupancy)
// -----------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 3
) (
  input  logic             clock,
  input  logic             reset,
  writeback_queue_if.slave wbq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_EXT  = (CW+1)'(DEPTH);
  localparam logic [CW:0] MARGIN_EXT = (CW+1)'(STALL_MARGIN);

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] value;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] hd;
  logic [PW-1:0] tl;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW:0]   free_slots;
  logic [CW:0]   free_next;
  logic          pop;

  logic [2:0]    req_vld;
  entry_t        req_ent [3];
  logic [2:0]    acc_vld;
  entry_t        acc_ent [3];
  logic [1:0]    num_acc;
  logic          any_drop;

  logic          reg_en;
  logic [4:0]    reg_addr;
  logic [31:0]   reg_data;
  logic          is_stall;
  logic          overflow;

  // Requests in priority order: slot 0 = M, 1 = X, 2 = Y.
  // Writes to r0 are dropped here so they never consume space or flag overflow.
  assign req_vld[0] = wbq.m_wb_writereg && (wbq.m_wb_regdest != 5'd0);
  assign req_vld[1] = wbq.x_wb_writereg && (wbq.x_wb_regdest != 5'd0);
  assign req_vld[2] = wbq.y_wb_writereg && (wbq.y_wb_regdest != 5'd0);

  assign req_ent[0] = '{dest: wbq.m_wb_regdest, value: wbq.m_wb_wbvalue};
  assign req_ent[1] = '{dest: wbq.x_wb_regdest, value: wbq.x_wb_wbvalue};
  assign req_ent[2] = '{dest: wbq.y_wb_regdest, value: wbq.y_wb_wbvalue};

  // The slot being popped this cycle is reusable by this cycle's pushes,
  // which is what lets a full queue still take one request while draining.
  assign pop        = (count != '0);
  assign free_slots = DEPTH_EXT - {1'b0, count} + (CW+1)'(pop);

  // Compact accepted requests into consecutive slots so they land at
  // tl, tl+1, tl+2 with no holes; anything past free_slots is dropped.
  always_comb begin
    num_acc  = '0;
    any_drop = 1'b0;
    acc_vld  = '0;
    for (int k = 0; k < 3; k++) begin
      acc_ent[k] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (req_vld[i]) begin
        if ((CW+1)'(num_acc) < free_slots) begin
          acc_ent[num_acc] = req_ent[i];
          acc_vld[num_acc] = 1'b1;
          num_acc          = num_acc + 2'd1;
        end else begin
          any_drop = 1'b1;
        end
      end
    end
  end

  assign count_next = count + CW'(num_acc) - CW'(pop);
  assign free_next  = DEPTH_EXT - {1'b0, count_next};

  // Entry storage has no reset: occupancy and pointers define what is live.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        if (acc_vld[k]) begin
          mem[tl + PW'(k)] <= acc_ent[k];
        end
      end
    end
  end

  // Pointers, occupancy and all registered outputs; reset wins over push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hd       <= '0;
      tl       <= '0;
      count    <= '0;
      reg_en   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      is_stall <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        reg_en   <= 1'b1;
        reg_addr <= mem[hd].dest;
        reg_data <= mem[hd].value;
        hd       <= hd + PW'(1);
      end else begin
        reg_en   <= 1'b0;
      end
      tl       <= tl + PW'(num_acc);
      count    <= count_next;
      is_stall <= (free_next <= MARGIN_EXT);
      if (any_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign wbq.wb_reg_en   = reg_en;
  assign wbq.wb_reg_addr = reg_addr;
  assign wbq.wb_reg_data = reg_data;
  assign wbq.wb_is_stall = is_stall;
  assign wbq.wb_overflow = overflow;
  assign wbq.wb_count    = count;

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (a queue of {addr,data}) predicts every registered output after each edge.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

  localparam int DEPTH        = 8;
  localparam int STALL_MARGIN = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  writeback_queue_if #(.DEPTH(DEPTH)) wb_if ();

  writeback_queue #(
    .DEPTH       (DEPTH),
    .STALL_MARGIN(STALL_MARGIN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wbq  (wb_if)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t        mq[$];
  logic        exp_en    = 1'b0;
  logic [4:0]  exp_addr  = '0;
  logic [31:0] exp_data  = '0;
  logic        exp_stall = 1'b0;
  logic        exp_ovf   = 1'b0;

  // Stimulus of the current cycle, index 0 = M, 1 = X, 2 = Y
  logic        stim_rst;
  logic [2:0]  stim_wr;
  logic [4:0]  stim_dst [3];
  logic [31:0] stim_val [3];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue-level rules: pop the oldest, then push qualified requests in
  // M, X, Y order while room remains; leftovers are dropped.
  task automatic modelStep();
    ent_t e;
    if (!stim_rst) begin
      mq.delete();
      exp_en    = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_stall = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        e        = mq.pop_front();
        exp_en   = 1'b1;
        exp_addr = e.addr;
        exp_data = e.data;
      end else begin
        exp_en   = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (stim_wr[i] && stim_dst[i] != 5'd0) begin
          if (mq.size() < DEPTH) mq.push_back('{addr: stim_dst[i], data: stim_val[i]});
          else exp_ovf = 1'b1;
        end
      end
      exp_stall = ((DEPTH - mq.size()) <= STALL_MARGIN);
    end
  endtask

  task automatic checkOutput();
    checkValue("wb_reg_en",   32'(wb_if.wb_reg_en),   32'(exp_en));
    checkValue("wb_reg_addr", 32'(wb_if.wb_reg_addr), 32'(exp_addr));
    checkValue("wb_reg_data", wb_if.wb_reg_data,      exp_data);
    checkValue("wb_is_stall", 32'(wb_if.wb_is_stall), 32'(exp_stall));
    checkValue("wb_overflow", 32'(wb_if.wb_overflow), 32'(exp_ovf));
    checkValue("wb_count",    32'(wb_if.wb_count),    32'(mq.size()));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare.
  task automatic applyStimulus(input logic rst_n, input logic [2:0] wr,
                               input logic [4:0] dm, input logic [31:0] vm,
                               input logic [4:0] dx, input logic [31:0] vx,
                               input logic [4:0] dy, input logic [31:0] vy);
    stim_rst = rst_n;
    stim_wr  = wr;
    stim_dst[0] = dm; stim_val[0] = vm;
    stim_dst[1] = dx; stim_val[1] = vx;
    stim_dst[2] = dy; stim_val[2] = vy;
    reset               = rst_n;
    wb_if.m_wb_writereg = wr[0]; wb_if.m_wb_regdest = dm; wb_if.m_wb_wbvalue = vm;
    wb_if.x_wb_writereg = wr[1]; wb_if.x_wb_regdest = dx; wb_if.x_wb_wbvalue = vx;
    wb_if.y_wb_writereg = wr[2]; wb_if.y_wb_regdest = dy; wb_if.y_wb_wbvalue = vy;
    @(posedge clock);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset state
    applyStimulus(1'b0, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    applyStimulus(1'b0, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    checkValue("reset_count", 32'(wb_if.wb_count), 32'd0);

    // Single write: X r5 = 0x1234, visible two edges later for one cycle
    applyStimulus(1'b1, 3'b010, 5'd0, 32'd0, 5'd5, 32'h1234, 5'd0, 32'd0);
    checkValue("single_en_early", 32'(wb_if.wb_reg_en), 32'd0);
    checkValue("single_count1",   32'(wb_if.wb_count),  32'd1);
    idleCycles(1);
    checkValue("single_en",   32'(wb_if.wb_reg_en),   32'd1);
    checkValue("single_addr", 32'(wb_if.wb_reg_addr), 32'd5);
    checkValue("single_data", wb_if.wb_reg_data,      32'h1234);
    idleCycles(2);

    // Triple burst M r1, X r2, Y r3
    applyStimulus(1'b1, 3'b111, 5'd1, 32'hA, 5'd2, 32'hB, 5'd3, 32'hC);
    checkValue("burst_peak",  32'(wb_if.wb_count),    32'd3);
    checkValue("burst_stall", 32'(wb_if.wb_is_stall), 32'd0);
    idleCycles(1);
    checkValue("burst_first", 32'(wb_if.wb_reg_addr), 32'd1);
    idleCycles(3);

    // r0 filter and same-destination ordering
    applyStimulus(1'b1, 3'b111, 5'd0, 32'h99, 5'd7, 32'd1, 5'd7, 32'd2);
    checkValue("r0_count", 32'(wb_if.wb_count), 32'd2);
    idleCycles(1);
    checkValue("same_dst_first", wb_if.wb_reg_data, 32'd1);
    idleCycles(1);
    checkValue("same_dst_second", wb_if.wb_reg_data, 32'd2);
    checkValue("r0_no_overflow", 32'(wb_if.wb_overflow), 32'd0);
    idleCycles(2);

    // Fill, stall, overflow: 3 requests per cycle for 4 cycles
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 3'b111, 5'd10, 32'(100 + 3*c), 5'd11, 32'(101 + 3*c),
                    5'd12, 32'(102 + 3*c));
      if (c == 1) checkValue("fill_stall", 32'(wb_if.wb_is_stall), 32'd1);
    end
    checkValue("fill_full",     32'(wb_if.wb_count),    32'd8);
    checkValue("fill_overflow", 32'(wb_if.wb_overflow), 32'd1);
    idleCycles(DEPTH + 2);

    // Reset clears the sticky overflow before the wrap test
    applyStimulus(1'b0, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    checkValue("ovf_cleared", 32'(wb_if.wb_overflow), 32'd0);

    // Wrap-around: 20 single writes, r(i mod 31)+1 = i
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'b010, 5'd0, 32'd0, 5'(i % 31 + 1), 32'(i), 5'd0, 32'd0);
    end
    idleCycles(2);

    // Reset mid-drain with 5 entries queued
    applyStimulus(1'b1, 3'b111, 5'd4, 32'h40, 5'd5, 32'h50, 5'd6, 32'h60);
    applyStimulus(1'b1, 3'b111, 5'd7, 32'h70, 5'd8, 32'h80, 5'd9, 32'h90);
    checkValue("pre_reset_count", 32'(wb_if.wb_count), 32'd5);
    applyStimulus(1'b0, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    checkValue("mid_reset_en",    32'(wb_if.wb_reg_en),   32'd0);
    checkValue("mid_reset_count", 32'(wb_if.wb_count),    32'd0);
    checkValue("mid_reset_stall", 32'(wb_if.wb_is_stall), 32'd0);
    idleCycles(3);
    checkValue("no_stale_write", 32'(wb_if.wb_reg_en), 32'd0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      logic       r;
      logic [2:0] w;
      r = ($urandom_range(63) != 0);
      for (int k = 0; k < 3; k++) w[k] = ($urandom_range(9) < 5);
      applyStimulus(r, w, 5'($urandom_range(31)), $urandom, 5'($urandom_range(31)), $urandom,
                    5'($urandom_range(31)), $urandom);
    end
    idleCycles(DEPTH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Order-preserving writeback queue between the three execute units (X, Y, M) and the register file's single write port. It replaces purely combinational result selection: up to three results may complete in one cycle, and all of them must reach the register file. The block enqueues every completing result into one shared FIFO and drains one entry per cycle onto the `wb_reg_*` port. It raises a stall toward Issue when the FIFO nears capacity.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, at least 4.
- `STALL_MARGIN`, 3, number of free entries at or below which `wb_is_stall` asserts.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; the block is in reset while `reset`=0 at a rising edge.
- `x_wb_regdest` in 5, `x_wb_writereg` in 1, `x_wb_wbvalue` in 32: X-unit result; valid when `x_wb_writereg`=1.
- `y_wb_regdest` in 5, `y_wb_writereg` in 1, `y_wb_wbvalue` in 32: Y-unit result, same rules as X.
- `m_wb_regdest` in 5, `m_wb_writereg` in 1, `m_wb_wbvalue` in 32: M-unit result, same rules as X.
- `wb_reg_en` out 1: register-file write enable; registered.
- `wb_reg_addr` out 5: register-file write address; registered.
- `wb_reg_data` out 32: register-file write data; registered.
- `wb_is_stall` out 1: stall request to Issue; registered.
- `wb_overflow` out 1: sticky flag, set when any result is dropped.
- `wb_count` out log2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Request qualification.** A request is a unit with `writereg`=1 and `regdest`≠0. Writes to r0 are discarded silently and do not set `wb_overflow`.
- **Storage.** Circular buffer of {regdest[4:0], value[31:0]}. Head pointer `hd`, tail pointer `tl`, and `count` are held separately so full and empty are unambiguous.
- **Pop.** `pop` = (`count`>0).
  - When `pop`=1: `wb_reg_en`<=1, `wb_reg_addr`/`wb_reg_data` <= entry[`hd`], and `hd` advances by 1 modulo DEPTH.
  - When `pop`=0: `wb_reg_en`<=0, and addr/data hold their previous values.
- **Push.**
  - Free slots this cycle: `free` = DEPTH − `count` + `pop`.
  - Qualified requests are accepted in fixed order M, then X, then Y, until `free` is exhausted.
  - Accepted entries are written to `tl`, `tl`+1, `tl`+2 (all modulo DEPTH), and `tl` advances by the number accepted.
- **Overflow.** Requests beyond `free` are dropped and set `wb_overflow`<=1. The flag is cleared only by reset.
- **Occupancy.** `count` <= `count` + accepted − `pop`. `wb_count` reflects the registered `count`.
- **Stall.** `wb_is_stall` <= ((DEPTH − `count_next`) ≤ STALL_MARGIN). Requests arriving while `wb_is_stall`=1 are still accepted, because operations already in flight must drain.
- **Same destination.** Multiple results to the same register in one cycle are all enqueued in M, X, Y order, so Y's value is the last one written. No coalescing is performed.
- **Reset** (`reset`=0 at an edge): `hd`=`tl`=`count`=0, `wb_reg_en`=0, `wb_reg_addr`=0, `wb_reg_data`=0, `wb_is_stall`=0, `wb_overflow`=0.
  - Reset takes priority over any push or pop in the same cycle.
  - Queued entries are lost.
  - Reset asserted mid-drain deasserts `wb_reg_en` on the next edge.

## Timing
- **Latency.** A request sampled at edge N into an empty queue drives `wb_reg_en`=1 with its data after edge N+1. Minimum latency is 2 edges, with no bypass.
- **Throughput.** One register write per cycle; bursts of up to 3 writes per cycle are absorbed by the FIFO.
- **Ordering.** The register file sees writes in arrival-cycle order; within a cycle the order is M, X, Y.
- **Stall timing.** `wb_is_stall` reflects occupancy after edge N, visible from cycle N+1 on.
- **Full with simultaneous pop.** At `count`=DEPTH with `pop`=1, exactly one new request is accepted.
- **Wrap-around.** `hd` and `tl` wrap modulo DEPTH without a bubble.

## Test plan
- **Single write.** Reset, then X writes r5=0x0000_1234 for one cycle. Expect `wb_reg_en`=1, addr 5, data 0x1234 exactly 2 edges later, lasting one cycle, with `wb_count` 0→1→0.
- **Triple burst.** M, X, Y write r1=0xA, r2=0xB, r3=0xC in the same cycle. Expect writes on 3 consecutive cycles in order r1, r2, r3, peak `wb_count`=3, and `wb_is_stall`=0 with DEPTH=8.
- **r0 filter and same-destination ordering.** M writes r0, X writes r7=1, and Y writes r7=2 in one cycle. Expect exactly 2 writes, r7=1 then r7=2, and `wb_overflow`=0.
- **Fill, stall, overflow.** Drive 3 requests per cycle for 4 cycles. Expect:
  - `wb_is_stall`=1 from the cycle after occupancy reaches 5;
  - the queue reaches full (`wb_count`=8);
  - `wb_overflow`=1 once a request finds `free`=0;
  - accepted entries drain in order and the dropped Y requests never appear.
- **Wrap-around.** Run 20 single writes with r(i mod 31)+1 and value i. Expect all 20 to appear in order with no gaps, after the pointers have wrapped twice.
- **Reset mid-drain.** With 5 entries queued, pull `reset`=0 for one edge. Expect on the next cycle `wb_reg_en`=0, `wb_count`=0 and `wb_is_stall`=0, with no stale writes afterwards.
